hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 54 +++++
 rtl/hazard_if.sv | 41 ++++
 rtl/hazard_detect.sv | 15 +
 rtl/hazard_ctrl.sv | 99 +++++++++
 tb/tb_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// the control-output bundle and helpers that build its standard values.
package hazard_pkg;

   localparam int unsigned REG_W = 5;
   localparam logic [6:0]  OPC_LOAD = 7'b0000011;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERROR    = 2'd2
   } state_e;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic control_sel;
      logic ifid_flush;
      logic idex_flush;
      logic pipe_freeze;
   } ctrl_t;

   function automatic ctrl_t ctrl_default();
      ctrl_t c;
      c             = '0;
      c.pc_write    = 1'b1;
      c.ifid_write  = 1'b1;
      return c;
   endfunction

   // Whole pipeline held while the data memory is busy or failed.
   function automatic ctrl_t ctrl_freeze();
      ctrl_t c;
      c             = '0;
      c.pipe_freeze = 1'b1;
      return c;
   endfunction

   // Normal-flow decision: a taken branch squashes the load-use stall.
   function automatic ctrl_t ctrl_run(input logic branch_taken, input logic load_use);
      ctrl_t c;
      c = ctrl_default();
      if (branch_taken) begin
         c.ifid_flush = 1'b1;
         c.idex_flush = 1'b1;
      end else if (load_use) begin
         c.pc_write    = 1'b0;
         c.ifid_write  = 1'b0;
         c.control_sel = 1'b1;
      end
      return c;
   endfunction

endpackage

// File: rtl/hazard_if.sv
// Pipeline <-> hazard controller signal bundle. The stall_cnt member
// exists only when HAZARD_PERF_EN is defined.
interface hazard_if;
   import hazard_pkg::*;

   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic [REG_W-1:0] idex_rd;
   logic             idex_memread;
   logic             ex_branch_taken;
   logic             dmem_req;
   logic             dmem_ready;

   logic             pc_write;
   logic             ifid_write;
   logic             control_sel;
   logic             ifid_flush;
   logic             idex_flush;
   logic             pipe_freeze;
   logic             mem_err;
`ifdef HAZARD_PERF_EN
   logic [15:0]      stall_cnt;
`endif

   modport master (
      output id_rs1, id_rs2, idex_rd, idex_memread, ex_branch_taken, dmem_req, dmem_ready,
      input  pc_write, ifid_write, control_sel, ifid_flush, idex_flush, pipe_freeze, mem_err
`ifdef HAZARD_PERF_EN
      , input stall_cnt
`endif
   );

   modport slave (
      input  id_rs1, id_rs2, idex_rd, idex_memread, ex_branch_taken, dmem_req, dmem_ready,
      output pc_write, ifid_write, control_sel, ifid_flush, idex_flush, pipe_freeze, mem_err
`ifdef HAZARD_PERF_EN
      , output stall_cnt
`endif
   );

endinterface

// File: rtl/hazard_detect.sv
// Load-use detector: the load in ID/EX writes a register the IF/ID
// instruction reads; x0 never creates a dependency.
module hazard_detect
   import hazard_pkg::*;
(
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   input  logic [REG_W-1:0] rd,
   input  logic             memread,
   output logic             load_use_c
);

   assign load_use_c = memread && (rd != REG_W'(0)) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and data-memory
// wait/timeout. Define HAZARD_PERF_EN to add the stall_cnt perf counter.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic     clk,
   input  logic     rst_n,
   hazard_if.slave  hz
);

   localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

   state_e           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   ctrl_t            ctl;
   logic             load_use;

   hazard_detect u_detect (
      .rs1        (hz.id_rs1),
      .rs2        (hz.id_rs2),
      .rd         (hz.idex_rd),
      .memread    (hz.idex_memread),
      .load_use_c (load_use)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state, wait counter and Mealy control outputs.
   always_comb begin
      ctl       = ctrl_default();
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_RUN: begin
            if (hz.dmem_req && !hz.dmem_ready) begin
               ctl       = ctrl_freeze();
               state_nxt = ST_MEM_WAIT;
               cnt_nxt   = CNT_W'(1);
            end else begin
               ctl = ctrl_run(hz.ex_branch_taken, load_use);
            end
         end
         ST_MEM_WAIT: begin
            if (!hz.dmem_ready) begin
               ctl = ctrl_freeze();
               if (cnt == CNT_W'(MEM_TIMEOUT - 1)) state_nxt = ST_ERROR;
               if (cnt < CNT_W'(MEM_TIMEOUT)) cnt_nxt = cnt + CNT_W'(1);
            end else begin
               ctl       = ctrl_run(hz.ex_branch_taken, load_use);
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end
         end
         ST_ERROR: begin
            ctl = ctrl_freeze();
         end
         default: begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
         end
      endcase
      // Outputs fall back to the free-running defaults as soon as reset asserts.
      if (!rst_n) ctl = ctrl_default();
   end

   assign hz.pc_write    = ctl.pc_write;
   assign hz.ifid_write  = ctl.ifid_write;
   assign hz.control_sel = ctl.control_sel;
   assign hz.ifid_flush  = ctl.ifid_flush;
   assign hz.idex_flush  = ctl.idex_flush;
   assign hz.pipe_freeze = ctl.pipe_freeze;
   assign hz.mem_err     = (state == ST_ERROR);

`ifdef HAZARD_PERF_EN
   logic [15:0] stall_q;

   // Saturating count of cycles in which the PC is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (!ctl.pc_write && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign hz.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a cycle-level behavioural model;
// also checks stall_cnt when built with HAZARD_PERF_EN.
module tb_hazard_ctrl;

   localparam int unsigned TB_TIMEOUT = 4;
   localparam logic [6:0]  O_DEF = 7'b1100000;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   // Model: stalled edges of the current access, sticky error, stall count.
   int   m_waited;
   bit   m_err;
   int   m_stall;

   hazard_if hz ();

   hazard_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_in(input int rs1, input int rs2, input int rd, input bit mr,
                         input bit br, input bit req, input bit rdy);
      hz.id_rs1          = 5'(rs1);
      hz.id_rs2          = 5'(rs2);
      hz.idex_rd         = 5'(rd);
      hz.idex_memread    = mr;
      hz.ex_branch_taken = br;
      hz.dmem_req        = req;
      hz.dmem_ready      = rdy;
   endtask

   // Expected {pc_write, ifid_write, control_sel, ifid_flush, idex_flush, pipe_freeze, mem_err}.
   function automatic logic [6:0] exp_out();
      bit lu;
      lu = hz.idex_memread && (hz.idex_rd != 0) &&
           (hz.idex_rd == hz.id_rs1 || hz.idex_rd == hz.id_rs2);
      if (!rst_n)                                           return O_DEF;
      if (m_err)                                            return 7'b0000011;
      if (!hz.dmem_ready && (m_waited > 0 || hz.dmem_req))  return 7'b0000010;
      if (hz.ex_branch_taken)                               return 7'b1101100;
      if (lu)                                               return 7'b0010000;
      return O_DEF;
   endfunction

   // One cycle: inputs already applied just after a rising edge; check at the
   // falling edge, then advance the model across the next rising edge.
   task automatic step(input string tag);
      logic [6:0] e;
      logic [6:0] a;
      e = exp_out();
      @(negedge clk);
      a = {hz.pc_write, hz.ifid_write, hz.control_sel, hz.ifid_flush,
           hz.idex_flush, hz.pipe_freeze, hz.mem_err};
      n_cmp++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: outputs got %b expected %b (t=%0t)", tag, a, e, $time);
      end
`ifdef HAZARD_PERF_EN
      n_cmp++;
      if (hz.stall_cnt !== 16'(m_stall)) begin
         n_err++;
         $display("FAIL %s: stall_cnt got %0d expected %0d", tag, hz.stall_cnt, m_stall);
      end
`endif
      @(posedge clk);
      if (!rst_n) begin
         m_waited = 0;
         m_err    = 0;
         m_stall  = 0;
      end else begin
         if (e[6] == 1'b0 && m_stall < 65535) m_stall++;
         if (!m_err) begin
            if (!hz.dmem_ready && (m_waited > 0 || hz.dmem_req)) begin
               m_waited++;
               if (m_waited == TB_TIMEOUT) m_err = 1;
            end else begin
               m_waited = 0;
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 1);
      step("reset_cycle");
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m_waited = 0; m_err = 0; m_stall = 0;
      // Hazard, branch and memory wait all presented while in reset.
      set_in(3, 3, 3, 1, 1, 1, 0);
      #2;
      step("reset_defaults");
      step("reset_defaults_2");
      rst_n = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 1);
      step("after_reset_idle");
   endtask

   task automatic test_load_use();
      set_in(1, 5, 5, 1, 0, 0, 1);
      step("load_use_rs2");
      set_in(1, 5, 5, 0, 0, 0, 1);      // bubble reached ID/EX
      step("load_use_released");
      set_in(5, 2, 5, 1, 0, 0, 1);
      step("load_use_rs1");
      set_in(0, 0, 0, 1, 0, 0, 1);
      step("load_use_x0");
      set_in(7, 8, 9, 1, 0, 0, 1);
      step("load_no_match");
      set_in(9, 9, 9, 0, 0, 0, 1);
      step("alu_dep_no_stall");
   endtask

   task automatic test_branch_priority();
      set_in(6, 4, 6, 1, 1, 0, 1);
      step("branch_over_load_use");
      set_in(0, 0, 0, 0, 1, 1, 1);
      step("branch_mem_ready");
      set_in(6, 4, 6, 1, 1, 1, 0);
      step("mem_over_branch");
      set_in(6, 4, 6, 1, 1, 1, 1);
      step("wait_exit_branch");
   endtask

   task automatic test_mem_wait();
      int freezes;
      freezes = 0;
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 0, 0, 0, 1, 0);
         step("mem_wait_freeze");
         if (exp_out() == 7'b0000010) freezes++;
      end
      set_in(0, 0, 0, 0, 0, 1, 1);
      step("mem_ready_release");
      set_in(0, 0, 0, 0, 0, 0, 1);
      step("mem_back_in_run");
      set_in(2, 3, 3, 1, 0, 0, 1);
      step("mem_then_load_use");
      set_in(0, 0, 0, 0, 0, 1, 0);
      step("mem_wait_again");
      set_in(4, 3, 4, 1, 0, 0, 1);
      step("wait_exit_load_use");
   endtask

   task automatic test_timeout();
      for (int i = 0; i < int'(TB_TIMEOUT); i++) begin
         set_in(0, 0, 0, 0, 0, 1, 0);
         step("timeout_stall");
      end
      n_cmp++;
      if (hz.mem_err !== 1'b1) begin
         n_err++;
         $display("FAIL timeout_entry: mem_err got %b expected 1", hz.mem_err);
      end
      set_in(0, 0, 0, 0, 1, 1, 1);
      step("error_sticky_ready");
      set_in(5, 0, 5, 1, 0, 0, 1);
      step("error_sticky_hazard");
      do_reset();
      set_in(0, 0, 0, 0, 0, 0, 1);
      step("error_cleared");
      set_in(0, 0, 0, 0, 0, 1, 0);
      step("mid_wait_enter");
      do_reset();
      set_in(0, 0, 0, 0, 0, 0, 0);
      step("mid_wait_aborted");
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 24) == 0 || (m_err && $urandom_range(0, 3) == 0)) begin
            do_reset();
         end
         set_in(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3,
                $urandom_range(0, 9) < 4);
         step("random");
      end
   endtask

`ifdef HAZARD_PERF_EN
   task automatic test_perf();
      do_reset();
      set_in(1, 5, 5, 1, 0, 0, 1);
      step("perf_lu1");
      set_in(5, 2, 5, 1, 0, 0, 1);
      step("perf_lu2");
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 0, 0, 0, 1, 0);
         step("perf_wait");
      end
      set_in(0, 0, 0, 0, 0, 1, 1);
      step("perf_ready");
      n_cmp++;
      if (hz.stall_cnt !== 16'd5) begin
         n_err++;
         $display("FAIL perf_total: stall_cnt got %0d expected 5", hz.stall_cnt);
      end
   endtask
`endif

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 1);
      test_reset();
      test_load_use();
      test_branch_priority();
      test_mem_wait();
      test_timeout();
      test_random();
`ifdef HAZARD_PERF_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
